branch_ctrl: RTL

- Branch resolution controller for the 16-bit pipelined core.
- Owns the architectural Z/V/N flag register and detects flag hazards against the instruction in EX.
- Evaluates the 3-bit branch condition of the instruction in ID, computes the target, and sequences the redirect and flush pulse to fetch.
- Keeps saturating taken/not-taken statistics counters.

---
 rtl/branch_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller: owns the Z/V/N flags, detects flag hazards
// against EX, resolves ID branches and sequences the redirect/flush pulse.
module branch_ctrl #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_stall,
  input  logic              flag_wr_en,
  input  logic [2:0]        flag_wr_mask,
  input  logic [2:0]        alu_flags,
  input  logic              br_valid,
  input  logic              br_is_reg,
  input  logic [2:0]        br_cond,
  input  logic [8:0]        br_imm,
  input  logic [ADDR_W-1:0] br_reg_target,
  input  logic [ADDR_W-1:0] pc_plus2,
  output logic              stall_id,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_ifid,
  output logic [2:0]        flags_q,
  output logic [CNT_W-1:0]  taken_cnt,
  output logic [CNT_W-1:0]  nottaken_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_FLAGS, REDIRECT} state_t;

  state_t            state;
  logic              redirect_q;
  logic [2:0]        l_cond;
  logic              l_is_reg;
  logic [8:0]        l_imm;
  logic [ADDR_W-1:0] l_reg_target;
  logic [ADDR_W-1:0] l_pc_plus2;

  // Flags are packed {Z, V, N}.
  function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (cond)
      3'd0:    return ~z;
      3'd1:    return z;
      3'd2:    return ~z & ~n;
      3'd3:    return n;
      3'd4:    return z | ~n;
      3'd5:    return z | n;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] pc_rel(input logic [ADDR_W-1:0] pc,
                                               input logic [8:0]        imm);
    logic [ADDR_W-1:0] offset;
    offset = {{(ADDR_W-10){imm[8]}}, imm, 1'b0};
    return pc + offset;
  endfunction

  logic              idle_br;
  logic              hazard;
  logic              resolve;
  logic              in_wait;
  logic [2:0]        sel_cond;
  logic              sel_is_reg;
  logic [8:0]        sel_imm;
  logic [ADDR_W-1:0] sel_reg_target;
  logic [ADDR_W-1:0] sel_pc_plus2;
  logic              taken;
  logic [ADDR_W-1:0] target;

  assign in_wait  = (state == WAIT_FLAGS);
  assign idle_br  = (state == IDLE) & br_valid & ~pipe_stall;
  assign hazard   = idle_br & flag_wr_en;
  assign resolve  = (idle_br & ~flag_wr_en) | (in_wait & ~pipe_stall);

  // After a hazard the branch resolves from its captured fields, otherwise from ID.
  assign sel_cond       = in_wait ? l_cond       : br_cond;
  assign sel_is_reg     = in_wait ? l_is_reg     : br_is_reg;
  assign sel_imm        = in_wait ? l_imm        : br_imm;
  assign sel_reg_target = in_wait ? l_reg_target : br_reg_target;
  assign sel_pc_plus2   = in_wait ? l_pc_plus2   : pc_plus2;

  assign taken  = cond_true(sel_cond, flags_q);
  assign target = sel_is_reg ? sel_reg_target : pc_rel(sel_pc_plus2, sel_imm);

  // NOTE: stall_id is combinational, so it is gated by rst_n explicitly to stay low in reset.
  assign stall_id   = rst_n & hazard;
  assign redirect   = redirect_q;
  assign flush_ifid = redirect_q;

  // NOTE: sequential state uses non-blocking assignments only; mixing in blocking ones creates races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      redirect_q   <= 1'b0;
      redirect_pc  <= '0;
      taken_cnt    <= '0;
      nottaken_cnt <= '0;
    end else if (!pipe_stall) begin
      redirect_q <= 1'b0;
      if (resolve) begin
        if (taken) begin
          redirect_pc <= target;
          redirect_q  <= 1'b1;
          state       <= REDIRECT;
          if (taken_cnt != '1) taken_cnt <= taken_cnt + CNT_W'(1);
        end else begin
          state <= IDLE;
          if (nottaken_cnt != '1) nottaken_cnt <= nottaken_cnt + CNT_W'(1);
        end
      end else if (hazard) begin
        state <= WAIT_FLAGS;
      end else if (state == REDIRECT) begin
        state <= IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (flag_wr_en && !pipe_stall) begin
      flags_q <= (flag_wr_mask & alu_flags) | (~flag_wr_mask & flags_q);
    end
  end

  // NOTE: captured branch fields need no reset; they are only read in WAIT_FLAGS, after being loaded.
  always_ff @(posedge clk) begin
    if (hazard) begin
      l_cond       <= br_cond;
      l_is_reg     <= br_is_reg;
      l_imm        <= br_imm;
      l_reg_target <= br_reg_target;
      l_pc_plus2   <= pc_plus2;
    end
  end

endmodule
